// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI command slave that feeds the 4-bit ALU.
package spi_alu_pkg;

    // Command frame: op[1:0], a[3:0], b[3:0], shifted in MSB first.
    localparam int FRAME_BITS = 10;
    localparam int OP_MSB     = 9;
    localparam int A_MSB      = 7;
    localparam int B_MSB      = 3;
    localparam int NIBBLE     = 4;

    typedef enum logic [1:0] {OP_AND, OP_OR, OP_ADD, OP_SUB} alu_op_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_APPLY, ST_CAPTURE} state_t;

    // Bit counter wide enough to hold FRAME_BITS; FULL_CNT also marks the drain phase.
    typedef logic [3:0] bit_cnt_t;
    localparam bit_cnt_t LAST_BIT = bit_cnt_t'(FRAME_BITS - 1);
    localparam bit_cnt_t FULL_CNT = bit_cnt_t'(FRAME_BITS);

endpackage

// File: rtl/spi_alu_cmd_slave_if.sv
// SPI pins and ALU operand/result bus of the command slave.
interface spi_alu_cmd_slave_if;
    import spi_alu_pkg::*;

    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    alu_op_t    alu_op;
    logic [3:0] alu_out;
    logic       cmd_valid;
    logic       frame_err;
    logic [3:0] result;

    modport slave (
        input  sclk, cs_n, mosi, alu_out,
        output miso, alu_a, alu_b, alu_op, cmd_valid, frame_err, result
    );

    modport master (
        output sclk, cs_n, mosi, alu_out,
        input  miso, alu_a, alu_b, alu_op, cmd_valid, frame_err, result
    );

endinterface

// File: rtl/spi_alu_cmd_slave_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered edge pulses.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rise_q;
    logic                   fall_q;

    // Shift the pin through the chain; flag a change as the last stage takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere in clocked blocks, so each stage
            // samples the previous stage's old value and the chain really delays.
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            rise_q <=  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall_q <= ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_alu_cmd_slave.sv
// SPI mode-0 slave: deserializes {op,a,b} for the ALU and returns its result next frame.
module spi_alu_cmd_slave
    import spi_alu_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_alu_cmd_slave_if.slave  bus
);

    logic                   sclk_level, sclk_rise, sclk_fall;
    logic                   cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    state_t                 state_q;
    bit_cnt_t               count_q;
    logic [FRAME_BITS-1:0]  rx_q;
    logic [FRAME_BITS-1:0]  tx_q;
    logic                   cs_pending_q;
    alu_op_t                alu_op_q;
    logic [3:0]             alu_a_q;
    logic [3:0]             alu_b_q;
    logic [3:0]             result_q;
    logic                   cmd_valid_q;
    logic                   frame_err_q;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.sclk),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // The cs_n chain resets to "selected": a master still mid-frame after reset
    // then produces no falling edge, so that frame is skipped until cs_n has
    // been seen high and falls again. miso stays 0 meanwhile because tx_q is 0.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.cs_n),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // Plain synchronizer for mosi; it is sampled on detected sclk rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Frame FSM: shift in the command, apply it, capture the ALU result, drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            cs_pending_q <= 1'b0;
            alu_op_q     <= OP_AND;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            result_q     <= '0;
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            // Remember a select that arrives while busy so IDLE can pick it up.
            if (cs_rise)      cs_pending_q <= 1'b0;
            else if (cs_fall) cs_pending_q <= 1'b1;

            // miso data advances on every master falling edge once a frame is open.
            if (state_q != ST_IDLE && sclk_fall)
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};

            case (state_q)
                ST_IDLE: begin
                    // Mode 0: a frame only opens with sclk at its idle-low level.
                    if ((cs_fall || cs_pending_q) && !sclk_level) begin
                        tx_q         <= {result_q, {(FRAME_BITS-NIBBLE){1'b0}}};
                        count_q      <= '0;
                        cs_pending_q <= 1'b0;
                        state_q      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The 10th bit wins over a simultaneous deselect.
                    if (sclk_rise && count_q == LAST_BIT) begin
                        rx_q    <= {rx_q[FRAME_BITS-2:0], mosi_s};
                        count_q <= FULL_CNT;
                        state_q <= ST_APPLY;
                    end else if (cs_rise) begin
                        if (count_q != FULL_CNT) frame_err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (sclk_rise && count_q != FULL_CNT) begin
                        rx_q    <= {rx_q[FRAME_BITS-2:0], mosi_s};
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_APPLY: begin
                    alu_op_q    <= alu_op_t'(rx_q[OP_MSB -: 2]);
                    alu_a_q     <= rx_q[A_MSB -: NIBBLE];
                    alu_b_q     <= rx_q[B_MSB -: NIBBLE];
                    cmd_valid_q <= 1'b1;
                    state_q     <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Operands have been stable for a full cycle; sample the ALU.
                    result_q <= bus.alu_out;
                    state_q  <= cs_level ? ST_IDLE : ST_SHIFT;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.miso      = ~cs_level & tx_q[FRAME_BITS-1];
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.result    = result_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_alu_cmd_slave.sv
// Self-checking bench: SPI master model, behavioural ALU and a command scoreboard.
module tb_spi_alu_cmd_slave;
    import spi_alu_pkg::*;

    localparam int HALF = 4;  // sclk half period in clk cycles

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
    } exp_t;

    typedef struct {
        logic [11:0] bits;       // left aligned, bit 11 sent first
        int          n;          // number of sclk cycles
        int          rst_after;  // pulse rst_n after this many bits, 0 = never
        logic [3:0]  res;        // ALU result the frame should leave behind
        int          gap;        // extra idle clocks after cs_n rises
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cmd_cnt = 0;
    int   err_cnt = 0;
    exp_t sb_q[$];
    logic res_pending = 1'b0;
    logic [3:0] res_exp;
    frame_t frames[10];

    always #5 clk = ~clk;

    spi_alu_cmd_slave_if bus ();

    spi_alu_cmd_slave #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [3:0] alu_model(input logic [1:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a + b;
            default: return a - b;
        endcase
    endfunction

    assign bus.alu_out = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: each cmd_valid pops one command, next cycle checks result.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_cnt++;
        if (res_pending) begin
            check("sb_result", bus.result, res_exp);
            res_pending = 1'b0;
        end
        if (bus.cmd_valid === 1'b1) begin
            exp_t e;
            cmd_cnt++;
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_alu_op", bus.alu_op, e.op);
                check("sb_alu_a", bus.alu_a, e.a);
                check("sb_alu_b", bus.alu_b, e.b);
                res_exp     = e.res;
                res_pending = 1'b1;
            end
        end
    end

    // SPI mode-0 master; samples miso just before each rising sclk.
    task automatic spi_frame(input logic [11:0] bits, input int n, input int rst_after,
                             output logic [11:0] miso_bits);
        miso_bits = '0;
        bus.cs_n  = 1'b0;
        bus.mosi  = bits[11];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            miso_bits[11-i] = bus.miso;
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
            if (i + 1 < n) bus.mosi = bits[10-i];
            if (i + 1 == rst_after) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check("midrst_result", bus.result, 0);
                check("midrst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
                check("midrst_pulses", {bus.miso, bus.cmd_valid, bus.frame_err}, 0);
                rst_n = 1'b1;
            end
            repeat (HALF) @(negedge clk);
        end
        bus.cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] miso_v;
        logic [3:0]  exp_res;
        logic [9:0]  exp_alu;
        int          c0, e0;
        logic        full;

        frames[0] = '{{10'b10_0011_0101, 2'b00}, 10, 0, 4'b1000, 10};  // ADD
        frames[1] = '{{10'b11_0010_0101, 2'b00}, 10, 0, 4'b1101, 10};  // SUB wrap
        frames[2] = '{{6'b01_1111, 6'b0},         6, 0, 4'b1101, 10};  // short
        frames[3] = '{12'b00_1111_1010_11,        12, 0, 4'b1010, 10}; // long AND
        frames[4] = '{{10'b10_1111_0001, 2'b00}, 10, 5, 4'b0000, 10};  // reset mid-frame
        frames[5] = '{{10'b01_0100_0001, 2'b00}, 10, 0, 4'b0101, 10};  // OR after reset
        frames[6] = '{{10'b10_1001_1000, 2'b00}, 10, 0, 4'b0001, 0};   // back-to-back ADD
        frames[7] = '{{10'b11_0001_0011, 2'b00}, 10, 0, 4'b1110, 0};   // back-to-back SUB
        frames[8] = '{{10'b00_1100_0110, 2'b00}, 10, 0, 4'b0100, 0};   // back-to-back AND
        frames[9] = '{{10'b01_0000_0000, 2'b00}, 10, 0, 4'b0000, 20};  // read back 0100

        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result", bus.result, 0);
        check("rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check("rst_pulses", {bus.miso, bus.cmd_valid, bus.frame_err}, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        exp_res = 4'b0000;
        exp_alu = 10'b0;
        foreach (frames[k]) begin
            c0   = cmd_cnt;
            e0   = err_cnt;
            full = (frames[k].n >= 10) && (frames[k].rst_after == 0);
            if (full)
                sb_q.push_back('{frames[k].bits[11:10], frames[k].bits[9:6],
                                 frames[k].bits[5:2], frames[k].res});
            spi_frame(frames[k].bits, frames[k].n, frames[k].rst_after, miso_v);
            check($sformatf("f%0d_miso", k), miso_v, {exp_res, 8'h00});
            repeat (frames[k].gap) @(negedge clk);
            if (full) begin
                exp_res = frames[k].res;
                exp_alu = frames[k].bits[11:2];
            end
            if (frames[k].rst_after != 0) begin
                exp_res = 4'b0000;
                exp_alu = 10'b0;
            end
            check($sformatf("f%0d_cmd_pulses", k), cmd_cnt - c0, full ? 1 : 0);
            check($sformatf("f%0d_err_pulses", k), err_cnt - e0,
                  (frames[k].n < 10 && frames[k].rst_after == 0) ? 1 : 0);
            check($sformatf("f%0d_result", k), bus.result, exp_res);
            check($sformatf("f%0d_alu", k), {bus.alu_op, bus.alu_a, bus.alu_b}, exp_alu);
        end

        check("sb_drained", sb_q.size(), 0);
        check("sb_no_pending", res_pending, 0);
        check("total_cmd_pulses", cmd_cnt, 8);
        check("total_err_pulses", err_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
